// File: rtl/util_io_sweep_test.sv
// Loopback I/O sweep tester: drives walk-1 / walk-0 / PRBS / checkerboard sweeps on io_o and
// checks io_i against a latency-aligned copy. Optional first-failure capture: UTIL_IO_SWEEP_FIRST_FAIL_EN.
module util_io_sweep_test #(
   parameter int          INPUT_IO_WIDTH  = 32,
   parameter int          OUTPUT_IO_WIDTH = 32,
   parameter int          TEST_GAP        = 512,
   parameter int          LOOP_LATENCY    = 1,
   parameter int          PRBS_LEN        = 64,
   parameter logic [30:0] PRBS_SEED       = 31'h7FFF_FFFF,
   parameter logic [31:0] DEFAULT_DIV     = 32'd99
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       en,
   input  logic                       clr,
   input  logic [1:0]                 mode,
   input  logic                       baud_load,
   input  logic [31:0]                baud_div,
   input  logic [OUTPUT_IO_WIDTH-1:0] force_default,
   input  logic [OUTPUT_IO_WIDTH-1:0] io_default,
   output logic [OUTPUT_IO_WIDTH-1:0] io_o,
   input  logic [INPUT_IO_WIDTH-1:0]  io_i,
   output logic [INPUT_IO_WIDTH-1:0]  state,
   output logic                       state_valid,
   output logic [15:0]                err_cnt,
   output logic [15:0]                sweep_cnt
`ifdef UTIL_IO_SWEEP_FIRST_FAIL_EN
   ,
   output logic                       fail_valid,
   output logic [7:0]                 fail_idx,
   output logic [7:0]                 fail_step
`endif
);

   localparam int              OW        = OUTPUT_IO_WIDTH;
   localparam int              IW        = INPUT_IO_WIDTH;
   localparam logic [15:0]     LAST_WALK = 16'(OUTPUT_IO_WIDTH - 1);
   localparam logic [15:0]     LAST_PRBS = 16'(PRBS_LEN - 1);
   localparam logic [31:0]     GAP_LAST  = 32'(TEST_GAP - 1);
   localparam logic [OW-1:0]   ONE_HOT0  = {{(OW-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      GAP  = 2'd2
   } fsm_t;

   fsm_t            fsm_q,   fsm_d;
   logic [15:0]     step_q,  step_d;
   logic [31:0]     cnt_q,   cnt_d;
   logic [31:0]     div_q,   div_d;
   logic [31:0]     gap_q,   gap_d;
   logic [30:0]     lfsr_q,  lfsr_d;
   logic [OW-1:0]   prbs_q,  prbs_d;
   logic [1:0]      mode_q,  mode_d;
   logic [OW-1:0]   io_o_q,  io_o_d;
   logic [IW-1:0]   state_q, state_d;
   logic            valid_q, valid_d;
   logic [15:0]     err_q,   err_d;
   logic [15:0]     sweep_q, sweep_d;

   logic            tick_s;
   logic            enter_s;
   logic            end_s;
   logic            lfsr_bit_s;
   logic [15:0]     last_s;
   logic [OW-1:0]   pat_s;
   logic [OW-1:0]   exp_s;
   logic [IW-1:0]   mism_s;

   // Expected pin values: io_o delayed by the external loop latency.
   generate
      if (LOOP_LATENCY == 0) begin : g_no_dly
         assign exp_s = io_o_q;
      end else begin : g_dly
         logic [OW-1:0] dly_q [LOOP_LATENCY];
         logic [OW-1:0] dly_d [LOOP_LATENCY];

         // Shift chain next-state.
         always_comb begin
            dly_d[0] = io_o_q;
            for (int k = 1; k < LOOP_LATENCY; k++) begin
               dly_d[k] = dly_q[k-1];
            end
         end

         // Shift chain registers.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int k = 0; k < LOOP_LATENCY; k++) begin
                  dly_q[k] <= '0;
               end
            end else begin
               for (int k = 0; k < LOOP_LATENCY; k++) begin
                  dly_q[k] <= dly_d[k];
               end
            end
         end

         assign exp_s = dly_q[LOOP_LATENCY-1];
      end
   endgenerate

   // Per-input mismatch; wider inputs wrap onto the output pins.
   always_comb begin
      mism_s = '0;
      for (int i = 0; i < IW; i++) begin
         mism_s[i] = io_i[i] ^ exp_s[i % OW];
      end
   end

   // Final step index of the latched pattern.
   always_comb begin
      case (mode_q)
         2'd0, 2'd1: last_s = LAST_WALK;
         2'd2:       last_s = LAST_PRBS;
         2'd3:       last_s = 16'd1;
         default:    last_s = LAST_WALK;
      endcase
   end

   // Sequencer, baud counter, pattern state and compare bookkeeping.
   always_comb begin
      fsm_d      = fsm_q;
      step_d     = step_q;
      cnt_d      = 32'd0;
      div_d      = div_q;
      gap_d      = 32'd0;
      lfsr_d     = lfsr_q;
      prbs_d     = prbs_q;
      mode_d     = mode_q;
      state_d    = state_q;
      err_d      = err_q;
      sweep_d    = sweep_q;
      valid_d    = 1'b0;
      tick_s     = 1'b0;
      enter_s    = 1'b0;
      end_s      = 1'b0;
      lfsr_bit_s = lfsr_q[30] ^ lfsr_q[27];

      case (fsm_q)
         IDLE: begin
            if (en) begin
               enter_s = 1'b1;
            end else begin
               fsm_d = IDLE;
            end
         end
         RUN: begin
            tick_s = (cnt_q == div_q);
            cnt_d  = tick_s ? 32'd0 : cnt_q + 32'd1;
            if (!en) begin
               fsm_d = IDLE;
            end else if (tick_s && (step_q == last_s)) begin
               fsm_d = GAP;
               end_s = 1'b1;
            end else begin
               fsm_d = RUN;
            end
         end
         GAP: begin
            if (!en) begin
               fsm_d = IDLE;
            end else if (gap_q == GAP_LAST) begin
               enter_s = 1'b1;
            end else begin
               gap_d = gap_q + 32'd1;
            end
         end
         default: fsm_d = IDLE;
      endcase

      if (tick_s) begin
         step_d  = step_q + 16'd1;
         state_d = state_q | mism_s;
         if ((|mism_s) && (err_q != 16'hFFFF)) begin
            err_d = err_q + 16'd1;
         end else begin
            err_d = err_q;
         end
         if (mode_q == 2'd2) begin
            lfsr_d = {lfsr_q[29:0], lfsr_bit_s};
            prbs_d = {prbs_q[OW-2:0], lfsr_bit_s};
         end else begin
            lfsr_d = lfsr_q;
            prbs_d = prbs_q;
         end
      end else begin
         step_d = step_q;
      end

      // Every sweep restarts from an identical pattern/LFSR state.
      if (enter_s) begin
         fsm_d  = RUN;
         step_d = 16'd0;
         cnt_d  = 32'd0;
         lfsr_d = PRBS_SEED;
         prbs_d = '0;
         mode_d = mode;
      end else begin
         mode_d = mode_q;
      end

      if (end_s) begin
         valid_d = 1'b1;
         sweep_d = sweep_q + 16'd1;
      end else begin
         valid_d = 1'b0;
      end

      if (baud_load) begin
         div_d = baud_div;
         cnt_d = 32'd0;
      end else begin
         div_d = div_q;
      end

      // clr beats a coincident mismatch or sweep end, but not the valid pulse.
      if (clr) begin
         state_d = '0;
         err_d   = 16'd0;
         sweep_d = 16'd0;
      end else begin
         state_d = state_d | '0;
      end
   end

   // Pin drive follows the next state so a stop or sweep end shows on the very next cycle.
   always_comb begin
      pat_s = io_default;
      if (fsm_d == RUN) begin
         case (mode_d)
            2'd0: pat_s = ONE_HOT0 << step_d;
            2'd1: pat_s = ~(ONE_HOT0 << step_d);
            2'd2: pat_s = prbs_d;
            2'd3: begin
               for (int j = 0; j < OW; j++) begin
                  pat_s[j] = ((j % 2) == 0) ^ step_d[0];
               end
            end
            default: pat_s = io_default;
         endcase
      end else begin
         pat_s = io_default;
      end
      io_o_d = (force_default & io_default) | (~force_default & pat_s);
   end

   // Main state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm_q   <= IDLE;
         step_q  <= 16'd0;
         cnt_q   <= 32'd0;
         div_q   <= DEFAULT_DIV;
         gap_q   <= 32'd0;
         lfsr_q  <= PRBS_SEED;
         prbs_q  <= '0;
         mode_q  <= 2'd0;
         io_o_q  <= '0;
         state_q <= '0;
         valid_q <= 1'b0;
         err_q   <= 16'd0;
         sweep_q <= 16'd0;
      end else begin
         fsm_q   <= fsm_d;
         step_q  <= step_d;
         cnt_q   <= cnt_d;
         div_q   <= div_d;
         gap_q   <= gap_d;
         lfsr_q  <= lfsr_d;
         prbs_q  <= prbs_d;
         mode_q  <= mode_d;
         io_o_q  <= io_o_d;
         state_q <= state_d;
         valid_q <= valid_d;
         err_q   <= err_d;
         sweep_q <= sweep_d;
      end
   end

   assign io_o        = io_o_q;
   assign state       = state_q;
   assign state_valid = valid_q;
   assign err_cnt     = err_q;
   assign sweep_cnt   = sweep_q;

`ifdef UTIL_IO_SWEEP_FIRST_FAIL_EN
   logic       fail_valid_q, fail_valid_d;
   logic [7:0] fail_idx_q,   fail_idx_d;
   logic [7:0] fail_step_q,  fail_step_d;
   logic [7:0] low_idx_s;

   // Capture the first failing tick since reset/clr; lowest input index wins.
   always_comb begin
      low_idx_s = 8'd0;
      for (int i = IW - 1; i >= 0; i--) begin
         if (mism_s[i]) begin
            low_idx_s = 8'(i);
         end else begin
            low_idx_s = low_idx_s | 8'd0;
         end
      end
      fail_valid_d = fail_valid_q;
      fail_idx_d   = fail_idx_q;
      fail_step_d  = fail_step_q;
      if (clr) begin
         fail_valid_d = 1'b0;
         fail_idx_d   = 8'd0;
         fail_step_d  = 8'd0;
      end else if (tick_s && (|mism_s) && !fail_valid_q) begin
         fail_valid_d = 1'b1;
         fail_idx_d   = low_idx_s;
         fail_step_d  = step_q[7:0];
      end else begin
         fail_valid_d = fail_valid_q;
      end
   end

   // First-failure registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fail_valid_q <= 1'b0;
         fail_idx_q   <= 8'd0;
         fail_step_q  <= 8'd0;
      end else begin
         fail_valid_q <= fail_valid_d;
         fail_idx_q   <= fail_idx_d;
         fail_step_q  <= fail_step_d;
      end
   end

   assign fail_valid = fail_valid_q;
   assign fail_idx   = fail_idx_q;
   assign fail_step  = fail_step_q;
`endif

endmodule

// File: tb/tb_util_io_sweep_test.sv
// Self-checking bench for util_io_sweep_test: randomized sweeps against a pattern-level reference model.
module tb_util_io_sweep_test;

   localparam int          W    = 32;
   localparam int          GAPN = 2;
   localparam int          PLEN = 64;
   localparam logic [30:0] SEED = 31'h7FFF_FFFF;

   logic          clk;
   logic          rst;
   logic          en;
   logic          clr;
   logic [1:0]    mode;
   logic          baud_load;
   logic [31:0]   baud_div;
   logic [W-1:0]  force_default;
   logic [W-1:0]  io_default;
   logic [W-1:0]  io_o;
   logic [W-1:0]  io_i;
   logic [W-1:0]  state;
   logic          state_valid;
   logic [15:0]   err_cnt;
   logic [15:0]   sweep_cnt;

   logic [W-1:0]  loop_q;
   logic [W-1:0]  stuck0;
   logic [W-1:0]  stuck1;

   int            n_cmp;
   int            n_bad;
   logic [W-1:0]  m_state;
   int            m_err;
   int            m_sweep;
   bit            prbs_bits [0:127];

   util_io_sweep_test #(
      .INPUT_IO_WIDTH (W),
      .OUTPUT_IO_WIDTH(W),
      .TEST_GAP       (GAPN),
      .LOOP_LATENCY   (1),
      .PRBS_LEN       (PLEN),
      .PRBS_SEED      (SEED),
      .DEFAULT_DIV    (32'd99)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .clr          (clr),
      .mode         (mode),
      .baud_load    (baud_load),
      .baud_div     (baud_div),
      .force_default(force_default),
      .io_default   (io_default),
      .io_o         (io_o),
      .io_i         (io_i),
      .state        (state),
      .state_valid  (state_valid),
      .err_cnt      (err_cnt),
      .sweep_cnt    (sweep_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One-register external loopback with injectable stuck-at faults.
   always @(posedge clk) loop_q <= io_o;
   assign io_i = (loop_q & ~stuck0) | stuck1;

   function automatic int n_steps(input logic [1:0] m);
      case (m)
         2'd0, 2'd1: return W;
         2'd2:       return PLEN;
         default:    return 2;
      endcase
   endfunction

   function automatic logic [W-1:0] model_pat(input logic [1:0] m, input int k);
      logic [W-1:0] p;
      p = '0;
      case (m)
         2'd0: p[k] = 1'b1;
         2'd1: begin p = '1; p[k] = 1'b0; end
         2'd2: begin
            for (int j = 0; j < W; j++) begin
               if (j < k) p[j] = prbs_bits[31 + k - 1 - j];
            end
         end
         default: p = (k == 0) ? 32'h5555_5555 : 32'hAAAA_AAAA;
      endcase
      return p;
   endfunction

   function automatic logic [W-1:0] drive(input logic [W-1:0] p);
      return (force_default & io_default) | (~force_default & p);
   endfunction

   task automatic model_compare(input logic [W-1:0] seen);
      logic [W-1:0] mism;
      mism = ((seen & ~stuck0) | stuck1) ^ seen;
      m_state = m_state | mism;
      if ((mism != '0) && (m_err < 65535)) m_err = m_err + 1;
   endtask

   task automatic do_sweep(input logic [1:0] m, input int div, input string tag);
      int           ns;
      logic [W-1:0] d;
      logic [W-1:0] prev;
      ns = n_steps(m);
      @(negedge clk);
      baud_div  = 32'(div);
      baud_load = 1'b1;
      @(negedge clk);
      baud_load = 1'b0;
      mode      = m;
      en        = 1'b1;
      prev      = io_default;
      for (int k = 0; k < ns; k++) begin
         d = drive(model_pat(m, k));
         model_compare((div == 0) ? prev : d);
         prev = d;
         for (int c = 0; c <= div; c++) begin
            @(negedge clk);
            mode = 2'($urandom_range(0, 3));
            n_cmp++;
            if (io_o !== d) begin
               n_bad++;
               $display("FAIL %s io_o step %0d: got %h want %h", tag, k, io_o, d);
            end
            n_cmp++;
            if (state_valid !== 1'b0) begin
               n_bad++;
               $display("FAIL %s early_valid step %0d: got %b want 0", tag, k, state_valid);
            end
         end
      end
      m_sweep = (m_sweep + 1) % 65536;
      @(negedge clk);
      n_cmp++;
      if (state_valid !== 1'b1) begin
         n_bad++;
         $display("FAIL %s valid_pulse: got %b want 1", tag, state_valid);
      end
      n_cmp++;
      if (io_o !== io_default) begin
         n_bad++;
         $display("FAIL %s gap_io: got %h want %h", tag, io_o, io_default);
      end
      n_cmp++;
      if (state !== m_state) begin
         n_bad++;
         $display("FAIL %s state: got %h want %h", tag, state, m_state);
      end
      n_cmp++;
      if (err_cnt !== 16'(m_err)) begin
         n_bad++;
         $display("FAIL %s err_cnt: got %0d want %0d", tag, err_cnt, m_err);
      end
      n_cmp++;
      if (sweep_cnt !== 16'(m_sweep)) begin
         n_bad++;
         $display("FAIL %s sweep_cnt: got %0d want %0d", tag, sweep_cnt, m_sweep);
      end
      en = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (state_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL %s valid_width: got %b want 0", tag, state_valid);
      end
   endtask

   task automatic do_clr(input string tag);
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr     = 1'b0;
      m_state = '0;
      m_err   = 0;
      m_sweep = 0;
      n_cmp++;
      if ((state !== '0) || (err_cnt !== 16'd0) || (sweep_cnt !== 16'd0)) begin
         n_bad++;
         $display("FAIL %s clr: got state=%h err=%0d sweep=%0d want 0/0/0", tag, state, err_cnt, sweep_cnt);
      end
   endtask

   task automatic test_reset;
      #12;
      n_cmp++;
      if ((io_o !== '0) || (state !== '0) || (state_valid !== 1'b0) ||
          (err_cnt !== 16'd0) || (sweep_cnt !== 16'd0)) begin
         n_bad++;
         $display("FAIL reset_outputs: got io_o=%h state=%h v=%b err=%0d sweep=%0d want all 0",
                  io_o, state, state_valid, err_cnt, sweep_cnt);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (io_o !== io_default) begin
         n_bad++;
         $display("FAIL idle_drive: got %h want %h", io_o, io_default);
      end
   endtask

   task automatic test_walk1;
      force_default = '0;
      stuck0 = '0;
      stuck1 = '0;
      do_sweep(2'd0, 3, "walk1");
   endtask

   task automatic test_stuck;
      stuck0 = 32'h0000_0020;
      do_sweep(2'd0, 3, "stuck5_a");
      do_sweep(2'd0, 3, "stuck5_b");
      stuck0 = '0;
      do_clr("stuck5");
   endtask

   task automatic test_force;
      force_default = 32'h0000_FFFF;
      io_default    = 32'h0000_FFFF;
      do_sweep(2'd1, 3, "force_clean");
      stuck0 = 32'h0000_0008;
      do_sweep(2'd1, 3, "force_pin3");
      stuck0 = '0;
      force_default = '0;
      do_clr("force");
   endtask

   task automatic test_prbs;
      io_default = $urandom;
      do_sweep(2'd2, 0, "prbs_a");
      do_sweep(2'd2, 0, "prbs_b");
   endtask

   task automatic test_checker;
      do_sweep(2'd3, 1, "checker");
   endtask

   task automatic test_random;
      for (int n = 0; n < 6; n++) begin
         force_default = $urandom & $urandom;
         io_default    = $urandom;
         stuck0        = $urandom & $urandom & $urandom;
         stuck1        = $urandom & $urandom & $urandom & ~stuck0;
         do_sweep(2'($urandom_range(0, 3)), $urandom_range(1, 3), "random");
      end
      force_default = '0;
      stuck0 = '0;
      stuck1 = '0;
   endtask

   task automatic test_abort_baud;
      logic [W-1:0] last;
      int           c1;
      int           c2;
      @(negedge clk);
      baud_div  = 32'd3;
      baud_load = 1'b1;
      @(negedge clk);
      baud_load = 1'b0;
      mode = 2'd0;
      en   = 1'b1;
      repeat (41) @(negedge clk);
      n_cmp++;
      if (io_o !== drive(model_pat(2'd0, 10))) begin
         n_bad++;
         $display("FAIL abort_step10: got %h want %h", io_o, drive(model_pat(2'd0, 10)));
      end
      en = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (io_o !== io_default) begin
         n_bad++;
         $display("FAIL abort_io: got %h want %h", io_o, io_default);
      end
      repeat (GAPN + 6) begin
         @(negedge clk);
         n_cmp++;
         if (state_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_valid: got %b want 0", state_valid);
         end
      end
      n_cmp++;
      if (sweep_cnt !== 16'(m_sweep)) begin
         n_bad++;
         $display("FAIL abort_sweep_cnt: got %0d want %0d", sweep_cnt, m_sweep);
      end
      mode = 2'd0;
      en   = 1'b1;
      repeat (6) @(negedge clk);
      baud_div  = 32'd7;
      baud_load = 1'b1;
      @(negedge clk);
      baud_load = 1'b0;
      last = io_o;
      c1 = -1;
      c2 = -1;
      for (int cyc = 1; (cyc <= 40) && (c2 < 0); cyc++) begin
         @(negedge clk);
         if (io_o !== last) begin
            if (c1 < 0) c1 = cyc;
            else c2 = cyc;
            last = io_o;
         end
      end
      n_cmp++;
      if ((c1 != 8) || (c2 - c1 != 8)) begin
         n_bad++;
         $display("FAIL baud_reload: got first=%0d period=%0d want first=8 period=8", c1, c2 - c1);
      end
      en = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_saturation;
      force_default = '1;
      io_default    = '1;
      stuck0        = 32'h1 << $urandom_range(0, 31);
      stuck1        = '0;
      do_clr("sat");
      baud_div  = 32'd0;
      baud_load = 1'b1;
      @(negedge clk);
      baud_load = 1'b0;
      mode = 2'd2;
      en   = 1'b1;
      repeat (68000) @(negedge clk);
      n_cmp++;
      if (err_cnt !== 16'hFFFF) begin
         n_bad++;
         $display("FAIL err_saturate: got %h want ffff", err_cnt);
      end
      n_cmp++;
      if (state !== stuck0) begin
         n_bad++;
         $display("FAIL sat_state: got %h want %h", state, stuck0);
      end
      repeat (200) @(negedge clk);
      n_cmp++;
      if (err_cnt !== 16'hFFFF) begin
         n_bad++;
         $display("FAIL err_hold: got %h want ffff", err_cnt);
      end
      rst = 1'b1;
      #1;
      n_cmp++;
      if ((io_o !== '0) || (state !== '0) || (state_valid !== 1'b0) ||
          (err_cnt !== 16'd0) || (sweep_cnt !== 16'd0)) begin
         n_bad++;
         $display("FAIL async_reset: got io_o=%h state=%h v=%b err=%0d sweep=%0d want all 0",
                  io_o, state, state_valid, err_cnt, sweep_cnt);
      end
      en = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      n_cmp   = 0;
      n_bad   = 0;
      m_state = '0;
      m_err   = 0;
      m_sweep = 0;
      for (int i = 0; i < 31; i++) prbs_bits[i] = SEED[30 - i];
      for (int n = 31; n < 128; n++) prbs_bits[n] = prbs_bits[n - 31] ^ prbs_bits[n - 28];
      rst           = 1'b1;
      en            = 1'b0;
      clr           = 1'b0;
      mode          = 2'd0;
      baud_load     = 1'b0;
      baud_div      = 32'd0;
      force_default = '0;
      io_default    = $urandom;
      stuck0        = '0;
      stuck1        = '0;

      test_reset();
      test_walk1();
      test_stuck();
      test_force();
      test_prbs();
      test_checker();
      test_random();
      test_abort_baud();
      test_saturation();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
